// File: rtl/proc_mem_pkg.sv
// Shared constants and state encoding for the output-data segment reader.
package proc_mem_pkg;
  localparam int DEF_WIDTH = 24;
  localparam int DEF_DEPTH = 90000;
  localparam int ADDR_W    = 17;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_FIN  = 3'd4
  } state_e;
endpackage

// File: rtl/dout_stream_reader_if.sv
// Byte stream from the reader to the serial transmitter (valid/ready).
interface dout_stream_reader_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/dout_stream_reader_serializer.sv
// Splits one memory word into bytes, MSB first, holding each byte until accepted.
module word_byte_serializer
  import proc_mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  dout_stream_reader_if.master tx,
  output logic             word_done
);
  localparam int NB = WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             vld;
  logic             hs;

  assign hs          = vld & tx.tx_ready;
  assign word_done   = hs && (cnt == CNT_LAST);
  assign tx.tx_data  = sr[WIDTH-1 -: 8];
  assign tx.tx_valid = vld;

  // sr only moves on a handshake, so a stalled byte stays put
  always_ff @(posedge clk) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
      vld <= 1'b0;
    end else if (load) begin
      sr  <= din;
      cnt <= '0;
      vld <= 1'b1;
    end else if (hs) begin
      sr <= sr << 8;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        vld <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/dout_stream_reader.sv
// Dumps len words of the output-data segment as a byte stream, 5 cycles per word.
module dout_stream_reader
  import proc_mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  output logic [WIDTH-1:0]  mem_addr,
  input  logic [WIDTH-1:0]  mem_rd,
  dout_stream_reader_if.master tx,
  output logic              busy,
  output logic              done
);
  state_e            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] len_c;
  logic              load;
  logic              word_done;

  // oversize requests are clamped so the address never runs past the segment
  always_comb len_c = (int'(len) > DEPTH) ? ADDR_W'(DEPTH) : len;
  assign load = (state == S_WAIT);

  // mem_addr is loaded on entry to ADDR so the synchronous read lands in WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      last_idx <= '0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          idx      <= '0;
          last_idx <= len_c - 1'b1;
          busy     <= 1'b1;
          if (len_c == '0) begin
            state <= S_FIN;
          end else begin
            mem_addr <= '0;
            state    <= S_ADDR;
          end
        end
        S_ADDR: state <= S_WAIT;
        S_WAIT: state <= S_SEND;
        S_SEND: if (word_done) begin
          if (idx == last_idx) begin
            state <= S_FIN;
          end else begin
            idx      <= idx + 1'b1;
            mem_addr <= WIDTH'(idx + 1'b1);
            state    <= S_ADDR;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  word_byte_serializer #(.WIDTH(WIDTH)) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .din       (mem_rd),
    .tx        (tx),
    .word_done (word_done)
  );
endmodule
